multi_line_fifo: RTL

Single-clock, line-granular FIFO for the video path. It is the parametrised successor of the fixed 5×640×8 line buffer, with configurable pixel width, line length and line count. Pixels are written one per cycle. A line becomes visible to the reader only after its last pixel is written. A partial line can be discarded with an abort strobe. It sits between the BT.656 decoder and the Avalon-ST output stage, and is used where both sides run on the same clock.

---
 rtl/multi_line_fifo_pkg.sv | 11 +
 rtl/multi_line_fifo_ram.sv | 47 ++++
 rtl/multi_line_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/multi_line_fifo_pkg.sv
// Shared constants and helpers for the line-granular video FIFO.
// Used by multi_line_fifo and its RAM sub-module.
package multi_line_fifo_pkg;

    localparam int DROP_CNT_W = 16;

    function automatic int cnt_width(input int num_lines);
        return $clog2(num_lines + 1);
    endfunction

endpackage

// File: rtl/multi_line_fifo_ram.sv
// Simple dual-port line memory with a registered read port.
// Words are addressed as slot * LINE_SIZE + pixel index.
module multi_line_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_SIZE  = 640,
    parameter int NUM_LINES  = 5,
    localparam int PX_W      = $clog2(LINE_SIZE),
    localparam int LN_W      = $clog2(NUM_LINES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [LN_W-1:0]       wr_slot,
    input  logic [PX_W-1:0]       wr_px,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [LN_W-1:0]       rd_slot,
    input  logic [PX_W-1:0]       rd_px,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH  = NUM_LINES * LINE_SIZE;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;

    assign wr_addr = ADDR_W'(wr_slot) * ADDR_W'(LINE_SIZE) + ADDR_W'(wr_px);
    assign rd_addr = ADDR_W'(rd_slot) * ADDR_W'(LINE_SIZE) + ADDR_W'(rd_px);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value between accepted reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/multi_line_fifo.sv
// Line-granular single-clock FIFO: a line becomes readable only once fully written.
// Optional dropped-write counter enabled by MULTI_LINE_FIFO_DROP_CNT_EN.
module multi_line_fifo
    import multi_line_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_SIZE  = 640,
    parameter int NUM_LINES  = 5,
    localparam int PX_W      = $clog2(LINE_SIZE),
    localparam int LN_W      = $clog2(NUM_LINES),
    localparam int CNT_W     = cnt_width(NUM_LINES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  wr_abort,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_eol,
    output logic                  empty,
    output logic [CNT_W-1:0]      lines_used
`ifdef MULTI_LINE_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [PX_W-1:0]  PX_LAST   = PX_W'(LINE_SIZE - 1);
    localparam logic [LN_W-1:0]  SLOT_LAST = LN_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_LINES);

    logic [PX_W-1:0] wr_px;
    logic [PX_W-1:0] rd_px;
    logic [LN_W-1:0] head;
    logic [LN_W-1:0] tail;

    logic            wr_accept;
    logic            rd_accept;
    logic            commit;
    logic            release_line;
    logic [PX_W-1:0] wr_px_eff;

    assign full  = (lines_used == CNT_FULL);
    assign empty = (lines_used == '0);

    assign wr_accept    = wr_en && !full;
    assign rd_accept    = rd_en && !empty;
    // An abort restarts the current line, so a coincident pixel lands at index 0.
    assign wr_px_eff    = wr_abort ? '0 : wr_px;
    assign commit       = wr_accept && !wr_abort && (wr_px == PX_LAST);
    assign release_line = rd_accept && (rd_px == PX_LAST);

    multi_line_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_SIZE  (LINE_SIZE),
        .NUM_LINES  (NUM_LINES)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_slot (head),
        .wr_px   (wr_px_eff),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_slot (tail),
        .rd_px   (rd_px),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_px <= '0;
            head  <= '0;
        end else if (wr_abort) begin
            wr_px <= wr_accept ? PX_W'(1) : '0;
        end else if (wr_accept) begin
            if (wr_px == PX_LAST) begin
                wr_px <= '0;
                head  <= (head == SLOT_LAST) ? '0 : head + LN_W'(1);
            end else begin
                wr_px <= wr_px + PX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_px    <= '0;
            tail     <= '0;
            rd_valid <= 1'b0;
            rd_eol   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            rd_eol   <= release_line;
            if (rd_accept) begin
                if (rd_px == PX_LAST) begin
                    rd_px <= '0;
                    tail  <= (tail == SLOT_LAST) ? '0 : tail + LN_W'(1);
                end else begin
                    rd_px <= rd_px + PX_W'(1);
                end
            end
        end
    end

    // Commit and release on the same edge cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lines_used <= '0;
        end else if (commit && !release_line) begin
            lines_used <= lines_used + CNT_W'(1);
        end else if (release_line && !commit) begin
            lines_used <= lines_used - CNT_W'(1);
        end
    end

`ifdef MULTI_LINE_FIFO_DROP_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (wr_en && full && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`else
    // Without the counter, writes presented while full are silently discarded.
`endif

endmodule
